// File: rtl/serdesphy_pll_cp_ctrl.sv
// rtl/serdesphy_pll_cp_ctrl.sv - PLL charge-pump acquisition/lock sequencer
module serdesphy_pll_cp_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int WINDOW        = 64,
    parameter int LOCK_THRESH   = 4,
    parameter int LOCK_WINDOWS  = 3,
    parameter int MAX_WINDOWS   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       up_pulse,
    input  logic       down_pulse,
    output logic       cp_enable,
    output logic [1:0] cp_current,
    output logic       locked,
    output logic       fail,
    output logic       lol,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_TRACK   = 3'd3,
        ST_FAIL    = 3'd4
    } state_t;

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int AW = $clog2(WINDOW + 1);
    localparam int QW = $clog2(LOCK_WINDOWS + 1);
    localparam int BW = $clog2(MAX_WINDOWS + 1);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [WW-1:0] WIN_LAST    = WW'(WINDOW - 1);
    localparam logic [AW-1:0] ACT_MAX     = {AW{1'b1}};
    localparam logic [AW-1:0] ACT_THRESH  = AW'(LOCK_THRESH);
    localparam logic [QW-1:0] QUIET_LOCK  = QW'(LOCK_WINDOWS);
    localparam logic [BW-1:0] BUDGET_MAX  = BW'(MAX_WINDOWS);

    state_t        st_q, st_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [WW-1:0] win_q, win_d;
    logic [AW-1:0] act_q, act_d, act_sum;
    logic [QW-1:0] quiet_q, quiet_d, quiet_inc;
    logic [BW-1:0] budget_q, budget_d, budget_inc;
    logic [1:0]    cur_d;
    logic          lol_d;
    logic          active;
    logic          win_end;
    logic          quiet_win;

    // State, counters and all outputs registered together so every output tracks the state edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= ST_IDLE;
            settle_q   <= '0;
            win_q      <= '0;
            act_q      <= '0;
            quiet_q    <= '0;
            budget_q   <= '0;
            cp_current <= 2'd0;
            cp_enable  <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
            lol        <= 1'b0;
        end else begin
            st_q       <= st_d;
            settle_q   <= settle_d;
            win_q      <= win_d;
            act_q      <= act_d;
            quiet_q    <= quiet_d;
            budget_q   <= budget_d;
            cp_current <= cur_d;
            cp_enable  <= (st_d == ST_SETTLE) || (st_d == ST_ACQUIRE) || (st_d == ST_TRACK);
            locked     <= (st_d == ST_TRACK);
            fail       <= (st_d == ST_FAIL);
            lol        <= lol_d;
        end
    end

    // Window bookkeeping: a one-sided detector pulse is activity; the ending cycle counts toward its own window
    always_comb begin
        active     = up_pulse ^ down_pulse;
        act_sum    = (act_q == ACT_MAX) ? act_q : act_q + AW'(active);
        win_end    = (win_q == WIN_LAST);
        quiet_win  = (act_sum <= ACT_THRESH);
        quiet_inc  = quiet_q + QW'(1);
        budget_inc = budget_q + BW'(1);
    end

    // Next-state and next-output decode
    always_comb begin
        st_d     = st_q;
        settle_d = settle_q;
        win_d    = win_q;
        act_d    = act_q;
        quiet_d  = quiet_q;
        budget_d = budget_q;
        cur_d    = cp_current;
        lol_d    = lol;

        if (st_q != ST_IDLE && !start) begin
            // Abort from anywhere; lol survives so software can still see it
            st_d     = ST_IDLE;
            settle_d = '0;
            win_d    = '0;
            act_d    = '0;
            quiet_d  = '0;
            budget_d = '0;
            cur_d    = 2'd0;
        end else begin
            case (st_q)
                ST_IDLE: begin
                    settle_d = '0;
                    win_d    = '0;
                    act_d    = '0;
                    quiet_d  = '0;
                    budget_d = '0;
                    cur_d    = 2'd0;
                    if (start) begin
                        st_d  = ST_SETTLE;
                        cur_d = 2'd3;
                        lol_d = 1'b0;
                    end
                end
                ST_SETTLE: begin
                    cur_d = 2'd3;
                    if (settle_q == SETTLE_LAST) begin
                        st_d     = ST_ACQUIRE;
                        settle_d = '0;
                        win_d    = '0;
                        act_d    = '0;
                        quiet_d  = '0;
                        budget_d = '0;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
                ST_ACQUIRE: begin
                    if (win_end) begin
                        win_d    = '0;
                        act_d    = '0;
                        budget_d = budget_inc;
                        if (quiet_win && cp_current > 2'd1) begin
                            cur_d   = cp_current - 2'd1;
                            quiet_d = '0;
                        end else if (quiet_win) begin
                            quiet_d = quiet_inc;
                        end else begin
                            quiet_d = '0;
                        end
                        // Lock wins over budget exhaustion on the same window end
                        if (quiet_win && cp_current == 2'd1 && quiet_inc == QUIET_LOCK) begin
                            st_d    = ST_TRACK;
                            quiet_d = '0;
                        end else if (budget_inc == BUDGET_MAX) begin
                            st_d  = ST_FAIL;
                            cur_d = 2'd0;
                        end
                    end else begin
                        win_d = win_q + WW'(1);
                        act_d = act_sum;
                    end
                end
                ST_TRACK: begin
                    if (win_end) begin
                        win_d = '0;
                        act_d = '0;
                        if (!quiet_win) begin
                            st_d     = ST_ACQUIRE;
                            cur_d    = 2'd3;
                            lol_d    = 1'b1;
                            quiet_d  = '0;
                            budget_d = '0;
                        end
                    end else begin
                        win_d = win_q + WW'(1);
                        act_d = act_sum;
                    end
                end
                ST_FAIL: begin
                    cur_d = 2'd0;
                end
                default: begin
                    st_d  = ST_IDLE;
                    cur_d = 2'd0;
                end
            endcase
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_serdesphy_pll_cp_ctrl.sv
// tb/tb_serdesphy_pll_cp_ctrl.sv - directed self-checking bench for serdesphy_pll_cp_ctrl
module tb_serdesphy_pll_cp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       up_pulse;
    logic       down_pulse;
    logic       cp_enable;
    logic [1:0] cp_current;
    logic       locked;
    logic       fail;
    logic       lol;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;
    int e     = 0;
    bit toggle_up = 1'b0;

    serdesphy_pll_cp_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .up_pulse   (up_pulse),
        .down_pulse (down_pulse),
        .cp_enable  (cp_enable),
        .cp_current (cp_current),
        .locked     (locked),
        .fail       (fail),
        .lol        (lol),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        e++;
        #1;
        if (toggle_up) up_pulse = ~up_pulse;
    endtask

    task automatic run_to(input int target);
        while (e < target) step();
    endtask

    task automatic do_reset();
        start      = 1'b0;
        up_pulse   = 1'b0;
        down_pulse = 1'b0;
        toggle_up  = 1'b0;
        rst_n      = 1'b0;
        #17;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Raise start so that the next rising edge is E0
    task automatic begin_seq();
        start = 1'b1;
        e     = -1;
        run_to(0);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tests++;
            if ({cp_enable, cp_current, locked, fail, lol, state} !== 8'h00) begin
                fails++;
                $display("FAIL reset_idle cyc%0d got en=%b cur=%0d lk=%b f=%b lol=%b st=%0d want all 0",
                         i, cp_enable, cp_current, locked, fail, lol, state);
            end
            step();
        end
    endtask

    task automatic test_lock_idle();
        do_reset();
        begin_seq();
        tests++;
        if (state !== 3'd1 || cp_current !== 2'd3 || cp_enable !== 1'b1) begin
            fails++;
            $display("FAIL settle_entry got st=%0d cur=%0d en=%b want 1 3 1", state, cp_current, cp_enable);
        end
        run_to(15);
        tests++;
        if (state !== 3'd1) begin fails++; $display("FAIL settle_e15 got st=%0d want 1", state); end
        run_to(16);
        tests++;
        if (state !== 3'd2 || cp_current !== 2'd3) begin
            fails++;
            $display("FAIL acq_e16 got st=%0d cur=%0d want 2 3", state, cp_current);
        end
        run_to(79);
        tests++;
        if (cp_current !== 2'd3) begin fails++; $display("FAIL cur_e79 got %0d want 3", cp_current); end
        run_to(80);
        tests++;
        if (cp_current !== 2'd2) begin fails++; $display("FAIL cur_e80 got %0d want 2", cp_current); end
        run_to(144);
        tests++;
        if (cp_current !== 2'd1) begin fails++; $display("FAIL cur_e144 got %0d want 1", cp_current); end
        run_to(335);
        tests++;
        if (state !== 3'd2 || locked !== 1'b0) begin
            fails++;
            $display("FAIL prelock_e335 got st=%0d lk=%b want 2 0", state, locked);
        end
        run_to(336);
        tests++;
        if (state !== 3'd3 || locked !== 1'b1 || cp_current !== 2'd1 || cp_enable !== 1'b1 || lol !== 1'b0) begin
            fails++;
            $display("FAIL lock_e336 got st=%0d lk=%b cur=%0d en=%b lol=%b want 3 1 1 1 0",
                     state, locked, cp_current, cp_enable, lol);
        end
    endtask

    // Continues from lock at E336; window ends fall on E400 and E464
    task automatic test_track();
        for (int i = 0; i < 4; i++) begin
            up_pulse = 1'b1; step();
            up_pulse = 1'b0; step();
        end
        run_to(400);
        tests++;
        if (state !== 3'd3 || locked !== 1'b1 || lol !== 1'b0) begin
            fails++;
            $display("FAIL track_4pulses got st=%0d lk=%b lol=%b want 3 1 0", state, locked, lol);
        end
        run_to(401);
        for (int i = 0; i < 5; i++) begin
            up_pulse = 1'b1; step();
            up_pulse = 1'b0; step();
        end
        run_to(463);
        tests++;
        if (state !== 3'd3) begin fails++; $display("FAIL track_e463 got st=%0d want 3", state); end
        run_to(464);
        tests++;
        if (state !== 3'd2 || locked !== 1'b0 || lol !== 1'b1 || cp_current !== 2'd3 || cp_enable !== 1'b1) begin
            fails++;
            $display("FAIL track_lol got st=%0d lk=%b lol=%b cur=%0d en=%b want 2 0 1 3 1",
                     state, locked, lol, cp_current, cp_enable);
        end
        start = 1'b0;
        step();
        tests++;
        if (state !== 3'd0 || lol !== 1'b1 || cp_enable !== 1'b0 || cp_current !== 2'd0) begin
            fails++;
            $display("FAIL abort_keeps_lol got st=%0d lol=%b en=%b cur=%0d want 0 1 0 0",
                     state, lol, cp_enable, cp_current);
        end
        start = 1'b1;
        step();
        tests++;
        if (state !== 3'd1 || lol !== 1'b0) begin
            fails++;
            $display("FAIL restart_clears_lol got st=%0d lol=%b want 1 0", state, lol);
        end
    endtask

    task automatic test_both_high();
        do_reset();
        up_pulse   = 1'b1;
        down_pulse = 1'b1;
        begin_seq();
        run_to(16);
        tests++;
        if (state !== 3'd2) begin fails++; $display("FAIL both_acq_e16 got st=%0d want 2", state); end
        run_to(80);
        tests++;
        if (cp_current !== 2'd2) begin fails++; $display("FAIL both_cur_e80 got %0d want 2", cp_current); end
        run_to(335);
        tests++;
        if (state !== 3'd2) begin fails++; $display("FAIL both_e335 got st=%0d want 2", state); end
        run_to(336);
        tests++;
        if (state !== 3'd3 || locked !== 1'b1) begin
            fails++;
            $display("FAIL both_lock_e336 got st=%0d lk=%b want 3 1", state, locked);
        end
    endtask

    task automatic test_fail();
        do_reset();
        toggle_up = 1'b1;
        begin_seq();
        run_to(80);
        tests++;
        if (cp_current !== 2'd3) begin fails++; $display("FAIL noisy_cur_e80 got %0d want 3", cp_current); end
        run_to(2063);
        tests++;
        if (state !== 3'd2 || fail !== 1'b0 || cp_current !== 2'd3) begin
            fails++;
            $display("FAIL prefail_e2063 got st=%0d f=%b cur=%0d want 2 0 3", state, fail, cp_current);
        end
        run_to(2064);
        tests++;
        if (state !== 3'd4 || fail !== 1'b1 || cp_enable !== 1'b0 || cp_current !== 2'd0) begin
            fails++;
            $display("FAIL fail_e2064 got st=%0d f=%b en=%b cur=%0d want 4 1 0 0",
                     state, fail, cp_enable, cp_current);
        end
        run_to(2070);
        tests++;
        if (state !== 3'd4 || fail !== 1'b1) begin
            fails++;
            $display("FAIL fail_hold got st=%0d f=%b want 4 1", state, fail);
        end
        toggle_up = 1'b0;
        start     = 1'b0;
        step();
        tests++;
        if (state !== 3'd0 || fail !== 1'b0) begin
            fails++;
            $display("FAIL fail_exit got st=%0d f=%b want 0 0", state, fail);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        begin_seq();
        run_to(30);
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({cp_enable, cp_current, locked, fail, lol, state} !== 8'h00) begin
            fails++;
            $display("FAIL async_reset got en=%b cur=%0d st=%0d want 0 0 0", cp_enable, cp_current, state);
        end
        start = 1'b0;
        #2;
        rst_n = 1'b1;
        step(); step(); step();
        tests++;
        if (state !== 3'd0 || cp_enable !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle got st=%0d en=%b want 0 0", state, cp_enable);
        end
    endtask

    task automatic test_abort_settle();
        do_reset();
        begin_seq();
        run_to(5);
        start = 1'b0;
        run_to(6);
        tests++;
        if (state !== 3'd0 || cp_enable !== 1'b0 || cp_current !== 2'd0) begin
            fails++;
            $display("FAIL abort_settle got st=%0d en=%b cur=%0d want 0 0 0", state, cp_enable, cp_current);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        up_pulse   = 1'b0;
        down_pulse = 1'b0;
        test_reset();
        test_lock_idle();
        test_track();
        test_both_high();
        test_fail();
        test_async_reset();
        test_abort_settle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
